// File: rtl/input_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | input_pkg                                                          |
// | Shared FSM states, button bit indices and 100 MHz timing defaults. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int c_BTN_UP    = 3;
  localparam int c_BTN_DOWN  = 2;
  localparam int c_BTN_LEFT  = 1;
  localparam int c_BTN_RIGHT = 0;

  localparam int c_DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int c_DEF_PULSE_W         = 16;
  localparam int c_DEF_REPEAT_DELAY    = 40_000_000;
  localparam int c_DEF_REPEAT_PERIOD   = 10_000_000;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_bit                                                       |
// | Two-flop synchroniser followed by a stable-level debounce counter. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module debounce_bit
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic debounced
);

  localparam int                 c_CNT_W    = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_deb;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign debounced = r_deb;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | button_conditioner                                                 |
// | Debounced button vector plus move strobe with auto-repeat.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module button_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_W         = c_DEF_PULSE_W,
  parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btns,
  output logic       btnClk2,
  output logic       pressed
);

  localparam int c_REP_MAX_A = (PULSE_W > REPEAT_DELAY) ? PULSE_W : REPEAT_DELAY;
  localparam int c_REP_MAX   = (c_REP_MAX_A > REPEAT_PERIOD) ? c_REP_MAX_A : REPEAT_PERIOD;
  localparam int c_REP_W     = cntWidth(c_REP_MAX);

  // The counter is cleared in LOAD and reads 0 the cycle before btnClk2 rises,
  // so a rise-to-rise spacing of N means leaving WAIT when it reads N-2.
  localparam logic [c_REP_W-1:0] c_PULSE_LAST  = c_REP_W'(PULSE_W - 1);
  localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 2);
  localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 2);

  logic [3:0]         w_deb;
  state_t             r_state;
  state_t             w_nextState;
  logic               w_loadFirst;
  logic [c_REP_W-1:0] w_repLast;
  logic [c_REP_W-1:0] r_repCnt;
  logic [3:0]         r_btns;
  logic               r_btnClk2;
  logic               r_pressed;
  logic               r_first;

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw       (btn_raw[gi]),
      .debounced (w_deb[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_loadFirst = 1'b0;
    w_repLast   = r_first ? c_DELAY_LAST : c_PERIOD_LAST;
    case (r_state)
      IDLE: begin
        if (w_deb != 4'd0) begin
          w_nextState = LOAD;
          w_loadFirst = 1'b1;
        end
      end
      LOAD: begin
        w_nextState = PULSE;
      end
      PULSE: begin
        if (r_repCnt == c_PULSE_LAST) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (w_deb == 4'd0) begin
          w_nextState = IDLE;
        end else if (w_deb != r_btns) begin
          w_nextState = LOAD;
          w_loadFirst = 1'b1;
        end else if (r_repCnt == w_repLast) begin
          w_nextState = LOAD;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btns    <= 4'd0;
      r_btnClk2 <= 1'b0;
      r_pressed <= 1'b0;
      r_first   <= 1'b0;
      r_repCnt  <= '0;
    end else begin
      r_pressed <= |w_deb;
      // Strobe trails PULSE by one cycle so btns is settled a cycle before it rises.
      r_btnClk2 <= (r_state == PULSE);
      if (r_state == LOAD) begin
        r_btns   <= w_deb;
        r_repCnt <= '0;
      end else if (r_state != IDLE) begin
        r_repCnt <= r_repCnt + 1'b1;
      end
      if (w_nextState == IDLE) begin
        r_btns <= 4'd0;
      end
      if (w_nextState == LOAD) begin
        r_first <= w_loadFirst;
      end
    end
  end

  assign btns    = r_btns;
  assign btnClk2 = r_btnClk2;
  assign pressed = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_button_conditioner                                              |
// | Randomised and directed bench against a timestamp-based model.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_button_conditioner;
  import input_pkg::*;

  localparam int D  = 4;
  localparam int PW = 2;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic [3:0] btn_raw = 4'd0;
  logic [3:0] btns;
  logic       btnClk2;
  logic       pressed;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_W        (PW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .btns    (btns),
    .btnClk2 (btnClk2),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int rises       = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sync delay line, window-of-D debounce, and a schedule of load/rise timestamps.
  logic [3:0] mS1, mS2, mDeb, mL, expBtns;
  logic       expPressed, expClk2;
  logic [3:0] mHist [D];
  int         cyc = 0;
  int         loadAt, riseAt;
  bit         busy, first;

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mDeb = '0; mL = '0; expBtns = '0;
    expPressed = 1'b0; expClk2 = 1'b0;
    for (int i = 0; i < D; i++) mHist[i] = '0;
    busy = 1'b0; first = 1'b0; loadAt = -1000; riseAt = -1000;
  endtask

  task automatic modelStep();
    logic [3:0] debPrev, s2Prev;
    bit allDiff;
    debPrev = mDeb;
    s2Prev  = mS2;
    expPressed = |debPrev;
    if (!busy) begin
      if (debPrev != 4'd0) begin busy = 1'b1; loadAt = cyc; first = 1'b1; end
    end else if (cyc == loadAt + 1) begin
      mL = debPrev; expBtns = debPrev; riseAt = cyc + 1;
    end else if (cyc >= loadAt + 2 + PW) begin
      if (debPrev == 4'd0) begin
        busy = 1'b0; expBtns = 4'd0;
      end else if (debPrev != mL) begin
        loadAt = cyc; first = 1'b1;
      end else if (cyc == riseAt + (first ? RD : RP) - 2) begin
        loadAt = cyc; first = 1'b0;
      end
    end
    expClk2 = (cyc >= riseAt) && (cyc < riseAt + PW);
    for (int i = D - 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = s2Prev;
    for (int b = 0; b < 4; b++) begin
      allDiff = 1'b1;
      for (int i = 0; i < D; i++) if (mHist[i][b] == mDeb[b]) allDiff = 1'b0;
      if (allDiff) mDeb[b] = ~mDeb[b];
    end
    mS2 = mS1;
    mS1 = btn_raw;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) modelReset();
      else     modelStep();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) check("reset_state", {btns, btnClk2, pressed}, 6'd0);
    else     check("model", {btns, btnClk2, pressed}, {expBtns, expClk2, expPressed});
  end

  initial forever begin
    @(posedge btnClk2);
    rises++;
  end

  task automatic idle(input int n);
    @(negedge clk);
    btn_raw = 4'd0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0;
    bit sawPressed;
    logic [3:0] v;

    #3 rst = 1'b1;
    #1 check("async_reset", {btns, btnClk2, pressed}, 6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(negedge clk);

    // Single press on UP
    r0 = rises;
    @(negedge clk) btn_raw = 4'(1 << c_BTN_UP);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (i == 6)  check("press_pressed_lo", 6'(pressed), 6'd0);
      if (i == 7)  check("press_pressed_hi", 6'(pressed), 6'd1);
      if (i == 8)  check("press_btns_before_rise", 6'({btns, btnClk2}), 6'b010000);
      if (i == 9)  begin check("press_rise", 6'(btnClk2), 6'd1); check("model_rise", 6'(expClk2), 6'd1); end
      if (i == 10) check("press_high2", 6'(btnClk2), 6'd1);
      if (i == 11) check("press_fall", 6'(btnClk2), 6'd0);
    end
    @(negedge clk) btn_raw = 4'd0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (j == 6) check("release_btns_held", 6'(btns), 6'b001000);
      if (j == 7) begin check("release_btns_clear", 6'(btns), 6'd0); check("model_clear", 6'(expBtns), 6'd0); end
    end
    check("press_single_rise", 6'(rises - r0), 6'd1);

    // Bounce on RIGHT: 2-cycle runs never reach the debounce threshold
    r0 = rises;
    sawPressed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 2 == 0) btn_raw[c_BTN_RIGHT] = ~btn_raw[c_BTN_RIGHT];
      if (pressed) sawPressed = 1'b1;
    end
    btn_raw = 4'd0;
    repeat (10) begin @(negedge clk); if (pressed) sawPressed = 1'b1; end
    check("bounce_no_rise", 6'(rises - r0), 6'd0);
    check("bounce_no_pressed", 6'(sawPressed), 6'd0);

    // Auto-repeat on LEFT
    r0 = rises;
    @(negedge clk) btn_raw = 4'(1 << c_BTN_LEFT);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 8 || i == 11 || i == 28 || i == 31 || i == 36)
        check("repeat_low", 6'(btnClk2), 6'd0);
      if (i == 9 || i == 10 || i == 29 || i == 30 || i == 37)
        check("repeat_high", 6'(btnClk2), 6'd1);
      if (i == 31) check("repeat_btns", 6'(btns), 6'b000010);
    end
    check("repeat_count", 6'(rises - r0), 6'd5);
    idle(30);

    // Combination change: UP then UP+RIGHT
    @(negedge clk) btn_raw = 4'b1000;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (i == 19) begin @(negedge clk); btn_raw = 4'b1001; end
      if (i == 26) check("combo_btns_old", 6'({btns, btnClk2}), 6'b010000);
      if (i == 27) check("combo_btns_new", 6'({btns, btnClk2}), 6'b010010);
      if (i == 28) check("combo_rise", 6'(btnClk2), 6'd1);
      if (i == 47) check("combo_delay_low", 6'(btnClk2), 6'd0);
      if (i == 48) check("combo_delay_rise", 6'({btns, btnClk2}), 6'b010011);
    end
    idle(30);

    // Reset in the middle of a pulse with DOWN still held
    @(negedge clk) btn_raw = 4'(1 << c_BTN_DOWN);
    for (int i = 1; i <= 9; i++) begin @(posedge clk); #1; end
    check("midpulse_high", 6'(btnClk2), 6'd1);
    #1 rst = 1'b1;
    #1 check("midpulse_reset", 6'({btns, btnClk2}), 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (j == 8) check("post_reset_btns", 6'({btns, btnClk2}), 6'b001000);
      if (j == 9) check("post_reset_rise", 6'(btnClk2), 6'd1);
    end
    idle(30);

    // Randomised segments
    for (int s = 0; s < 60; s++) begin
      int kind, len;
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 30);
      @(negedge clk);
      if (kind == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
      end else if (kind < 5) begin
        btn_raw = 4'd0;
        repeat (len) @(negedge clk);
      end else if (kind < 9) begin
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 1) == 1) btn_raw = btn_raw ^ 4'($urandom_range(0, 15));
        end
      end else begin
        v = 4'($urandom_range(1, 15));
        btn_raw = v;
        repeat (len * 3) @(negedge clk);
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
